ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Instruction-fetch stage sitting between the PC register and decode.
- Each cycle it takes the registered PC and issues at most one outstanding request to instruction memory over a valid/ready handshake.
- Returned instructions are buffered together with their PC in a small FIFO and presented to decode over a valid/ready handshake.
- It produces next_pc for the PC register: hold, sequential +4, or redirect target from the branch/jump unit, which also flushes the buffer.

Parameters:
BUF_DEPTH, 2, number of {pc, instr} entries in the fetch buffer (legal values 1..4).

Ports:
clk  input  1  clock
reset  input  1  reset, asynchronous, active-low
pc  input  32  current PC from the PC register
next_pc  output  32  value loaded into the PC register on the next rising edge
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  instruction memory accepts request
imem_req_addr  output  32  fetch address (equals pc)
imem_rsp_valid  input  1  response valid (one response per accepted request, in order)
imem_rsp_data  input  32  instruction word
redirect_valid  input  1  taken branch/jump/trap redirect, single-cycle pulse
redirect_pc  input  32  redirect target
inst_valid  output  1  buffer head valid to decode
inst_ready  input  1  decode consumes head
inst_data  output  32  head instruction
inst_pc  output  32  PC of head instruction
fetch_fault  output  1  sticky misaligned-redirect fault

Behaviour:
- Reset (reset low, async): state=REQ, buffer count=0, fetch_fault=0, req_pc=0. Outputs during and after reset until the first request: inst_valid=0, imem_req_valid=0. inst_data/inst_pc=0 while the buffer is empty.
- FSM states: REQ (may issue), WAIT (one request outstanding), DRAIN (outstanding response to be discarded).
- imem_req_valid = (state==REQ) && (count<BUF_DEPTH) && !fetch_fault && !redirect_valid. imem_req_addr = pc.
- Request handshake: valid&&ready at a clock edge latches req_pc=pc and moves to WAIT.
- next_pc (combinational), priority order:
  1. redirect_valid -> redirect_pc.
  2. Request handshake this cycle -> pc+4 (mod 2^32; 0xFFFFFFFC wraps to 0x00000000).
  3. Otherwise -> pc (hold).
- WAIT:
  - imem_rsp_valid pushes {req_pc, imem_rsp_data} to the buffer tail and returns to REQ.
  - No new request is issued in the same cycle as a response (max throughput one instruction per 2 cycles with 1-cycle memory).
- Response latency is at least one cycle after acceptance. A response is never accepted in REQ; rsp_valid in REQ is a protocol error and is ignored.
- Buffer: FIFO with push from a response and pop on inst_valid&&inst_ready.
  - Simultaneous push and pop keeps count unchanged.
  - Overflow cannot occur because a request is only issued while count<BUF_DEPTH.
  - inst_valid = (count!=0). inst_data/inst_pc reflect the head and are stable while inst_valid&&!inst_ready.
- Redirect (redirect_valid=1):
  - Buffer flushed (count=0 next cycle); any pop that cycle is ignored.
  - No request is issued that cycle.
  - From WAIT without rsp_valid -> DRAIN. From WAIT with rsp_valid in the same cycle -> response discarded, go to REQ.
  - In DRAIN -> stay in DRAIN. In REQ -> stay in REQ.
- DRAIN: the next imem_rsp_valid is discarded, then go to REQ. No requests are issued in DRAIN.
- Misalignment: if redirect_valid && redirect_pc[1:0]!=0, fetch_fault is set the next cycle. next_pc still = redirect_pc.
  - While fetch_fault=1: no requests, next_pc=pc.
  - Cleared by a later redirect with an aligned target (fault=0 from the following cycle).
- Reset asserted mid-operation:
  - State, buffer and fault are cleared immediately; an outstanding request is forgotten.
  - The memory is reset by the same signal and will not respond afterwards.

Test Plan:
- Reset release with pc=0, imem_req_ready=1, 1-cycle memory returning 0x00000013 -> requests at 0x0,0x4,0x8 on alternating cycles; inst_pc sequence 0x0,0x4,0x8; inst_data=0x00000013; next_pc=0x4 in the cycle of the first handshake.
- Decode stalled (inst_ready=0), BUF_DEPTH=2 -> after two responses count=2, imem_req_valid=0, next_pc holds pc=0x8; releasing inst_ready for one cycle pops 0x0 and a request for 0x8 issues the cycle after.
- Redirect to 0x100 while a request for 0x8 is outstanding and the buffer holds 0x4 -> buffer empties, DRAIN state, late response for 0x8 discarded, next request addr=0x100, first inst_pc=0x100.
- Redirect coincident with rsp_valid in WAIT -> response dropped, inst_valid stays 0, next request at the redirect target.
- Redirect to 0x102 -> fetch_fault=1 next cycle, no imem_req_valid, pc frozen at 0x102; redirect to 0x200 -> fault clears, fetch resumes at 0x200.
- pc=0xFFFFFFFC request accepted -> next_pc=0x00000000; async reset asserted during WAIT -> inst_valid=0, imem_req_valid=0, fetch_fault=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: issues one outstanding imem request at a time,
// buffers returned {pc, instr} pairs in a small FIFO for decode, and computes
// the next PC (hold / +4 / redirect). Misaligned redirects raise a sticky fault
// that blocks fetching until an aligned redirect arrives.
module ifetch_unit #(
  parameter int BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_fault
);

  localparam logic [2:0] DEPTH_C = 3'(BUF_DEPTH);
  localparam logic [1:0] LAST_C  = 2'(BUF_DEPTH - 1);

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_req_pc;
  logic        r_fault;
  logic [2:0]  r_count;
  logic [1:0]  r_head;
  logic [1:0]  r_tail;
  // Storage is sized for the largest legal depth; pointers wrap at BUF_DEPTH.
  logic [31:0] r_buf_pc   [0:3];
  logic [31:0] r_buf_data [0:3];

  logic w_req_valid;
  logic w_req_fire;
  logic w_push;
  logic w_pop;
  logic w_has_entry;

  // Circular pointer advance that wraps at the configured depth.
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    ptr_inc = (p == LAST_C) ? 2'd0 : (p + 2'd1);
  endfunction

  // Request gating; reset is included so nothing is requested while held in reset.
  always_comb begin
    w_req_valid = 1'b0;
    if (reset && (r_state == ST_REQ) && (r_count < DEPTH_C) && !r_fault && !redirect_valid) begin
      w_req_valid = 1'b1;
    end else begin
      w_req_valid = 1'b0;
    end
  end

  assign w_req_fire  = w_req_valid && imem_req_ready;
  assign w_has_entry = (r_count != 3'd0);
  // A response completes the outstanding fetch only when no redirect kills it.
  assign w_push      = (r_state == ST_WAIT) && imem_rsp_valid && !redirect_valid;
  // A redirect flushes the buffer, so a same-cycle pop is meaningless.
  assign w_pop       = w_has_entry && inst_ready && !redirect_valid;

  // Next-PC select: redirect wins, then sequential advance on an accepted request.
  always_comb begin
    next_pc = pc;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (w_req_fire) begin
      next_pc = pc + 32'd4;
    end else begin
      next_pc = pc;
    end
  end

  // Head-of-buffer view for decode; zeros when empty.
  always_comb begin
    inst_data = 32'd0;
    inst_pc   = 32'd0;
    if (w_has_entry) begin
      inst_data = r_buf_data[r_head];
      inst_pc   = r_buf_pc[r_head];
    end else begin
      inst_data = 32'd0;
      inst_pc   = 32'd0;
    end
  end

  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = pc;
  assign inst_valid     = w_has_entry;
  assign fetch_fault    = r_fault;

  // Fetch FSM plus sticky misalignment fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= ST_REQ;
      r_req_pc <= 32'd0;
      r_fault  <= 1'b0;
    end else begin
      if (redirect_valid) begin
        r_fault <= (redirect_pc[1:0] != 2'b00);
      end
      case (r_state)
        ST_REQ: begin
          if (w_req_fire) begin
            r_state  <= ST_WAIT;
            r_req_pc <= pc;
          end
        end
        ST_WAIT: begin
          // A response returns to REQ whether kept or killed by a redirect.
          if (imem_rsp_valid) begin
            r_state <= ST_REQ;
          end else if (redirect_valid) begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          // The stale response is swallowed; further redirects keep draining.
          if (imem_rsp_valid) begin
            r_state <= ST_REQ;
          end
        end
        default: begin
          r_state <= ST_REQ;
        end
      endcase
    end
  end

  // Fetch buffer FIFO: push from memory responses, pop to decode, flush on redirect.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 3'd0;
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
      for (int i = 0; i < 4; i++) begin
        r_buf_pc[i]   <= 32'd0;
        r_buf_data[i] <= 32'd0;
      end
    end else if (redirect_valid) begin
      r_count <= 3'd0;
      r_head  <= 2'd0;
      r_tail  <= 2'd0;
    end else begin
      if (w_push) begin
        r_buf_pc[r_tail]   <= r_req_pc;
        r_buf_data[r_tail] <= imem_rsp_data;
        r_tail             <= ptr_inc(r_tail);
      end
      if (w_pop) begin
        r_head <= ptr_inc(r_head);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 3'd1;
        2'b01:   r_count <= r_count - 3'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a per-cycle vector table (stimulus plus
// expected outputs) with a scoreboard queue for instruction words, followed by
// hand-written async-reset sequences.
module tb_ifetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        fetch_fault;

  ifetch_unit #(.BUF_DEPTH(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc             (pc),
    .next_pc        (next_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // rsp: 0 = no response, 1 = response expected to be buffered, 2 = response expected discarded
  typedef struct {
    logic        rst;
    logic        rdy;
    logic        mreq;
    logic        rv;
    logic [31:0] rpc;
    logic [1:0]  rsp;
    logic        e_req;
    logic [31:0] e_npc;
    logic        e_iv;
    logic [31:0] e_ipc;
    logic        e_flt;
  } vec_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb[$];
  int          n_vec;
  int          n_err;
  logic [31:0] pc_q;
  logic [31:0] mem_addr;
  logic [31:0] acc;
  logic [31:0] exp_d;
  logic [31:0] exp_p;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    mem_word = {a[19:0], 12'h013};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input int rst, input int rdy, input int mreq, input int rv,
                     input logic [31:0] rpc, input int rsp, input int e_req,
                     input logic [31:0] e_npc, input int e_iv, input logic [31:0] e_ipc,
                     input int e_flt);
    vec_t v;
    v.rst   = (rst != 0);
    v.rdy   = (rdy != 0);
    v.mreq  = (mreq != 0);
    v.rv    = (rv != 0);
    v.rpc   = rpc;
    v.rsp   = 2'(rsp);
    v.e_req = (e_req != 0);
    v.e_npc = e_npc;
    v.e_iv  = (e_iv != 0);
    v.e_ipc = e_ipc;
    v.e_flt = (e_flt != 0);
    tbl.push_back(v);
  endtask

  initial begin
    vec_t r;
    n_vec = 0;
    n_err = 0;
    pc_q = 32'd0;
    mem_addr = 32'd0;
    acc = 32'd0;

    //  rst rdy mreq rv  rpc            rsp  req  npc             iv  ipc            flt
    // Streaming with 1-cycle memory
    add(1, 1, 1, 0, 32'h0,          0,   1, 32'h4,          0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          1,   0, 32'h4,          0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h8,          1, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          1,   0, 32'h8,          0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'hC,          1, 32'h4,          0);
    add(0, 1, 1, 0, 32'h0,          1,   0, 32'hC,          0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h10,         1, 32'h8,          0);
    // Decode stall fills buffer, then one pop re-enables fetch
    add(1, 0, 1, 0, 32'h0,          0,   1, 32'h4,          0, 32'h0,          0);
    add(0, 0, 1, 0, 32'h0,          1,   0, 32'h4,          0, 32'h0,          0);
    add(0, 0, 1, 0, 32'h0,          0,   1, 32'h8,          1, 32'h0,          0);
    add(0, 0, 1, 0, 32'h0,          1,   0, 32'h8,          1, 32'h0,          0);
    add(0, 0, 1, 0, 32'h0,          0,   0, 32'h8,          1, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   0, 32'h8,          1, 32'h0,          0);
    add(0, 0, 1, 0, 32'h0,          0,   1, 32'hC,          1, 32'h4,          0);
    add(0, 0, 1, 0, 32'h0,          0,   0, 32'hC,          1, 32'h4,          0);
    // Redirect while request for 0x8 outstanding -> DRAIN, late response dropped
    add(0, 0, 1, 1, 32'h100,        0,   0, 32'h100,        1, 32'h4,          0);
    add(0, 0, 1, 0, 32'h0,          2,   0, 32'h100,        0, 32'h0,          0);
    add(0, 1, 0, 0, 32'h0,          0,   1, 32'h100,        0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h104,        0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          1,   0, 32'h104,        0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h108,        1, 32'h100,        0);
    // Redirect coincident with response in WAIT
    add(0, 1, 1, 1, 32'h300,        2,   0, 32'h300,        0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h304,        0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          1,   0, 32'h304,        0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h308,        1, 32'h300,        0);
    add(0, 1, 1, 0, 32'h0,          1,   0, 32'h308,        0, 32'h0,          0);
    // Misaligned redirect, then aligned redirect clears the fault
    add(0, 1, 1, 1, 32'h102,        0,   0, 32'h102,        1, 32'h304,        0);
    add(0, 1, 1, 0, 32'h0,          0,   0, 32'h102,        0, 32'h0,          1);
    add(0, 1, 1, 0, 32'h0,          0,   0, 32'h102,        0, 32'h0,          1);
    add(0, 1, 1, 1, 32'h200,        0,   0, 32'h200,        0, 32'h0,          1);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h204,        0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          1,   0, 32'h204,        0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h208,        1, 32'h200,        0);
    // PC wrap at top of address space
    add(1, 1, 1, 1, 32'hFFFFFFFC,   0,   0, 32'hFFFFFFFC,   0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h0,          0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          1,   0, 32'h0,          0, 32'h0,          0);
    add(0, 1, 1, 0, 32'h0,          0,   1, 32'h4,          1, 32'hFFFFFFFC,   0);
    add(0, 0, 1, 0, 32'h0,          1,   0, 32'h4,          0, 32'h0,          0);
    add(0, 0, 1, 0, 32'h0,          0,   1, 32'h8,          1, 32'h0,          0);

    // Power-on reset state
    reset = 1'b0;
    pc = 32'd0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data = 32'd0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    inst_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_inst_data", inst_data, 32'd0);

    for (int i = 0; i < tbl.size(); i++) begin
      r = tbl[i];
      if (r.rst) begin
        reset = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        sb.delete();
        pc_q = 32'd0;
        mem_addr = 32'd0;
      end
      pc             = pc_q;
      inst_ready     = r.rdy;
      imem_req_ready = r.mreq;
      redirect_valid = r.rv;
      redirect_pc    = r.rpc;
      imem_rsp_valid = (r.rsp != 2'd0);
      imem_rsp_data  = mem_word(mem_addr);
      @(negedge clk);
      chk($sformatf("v%0d_req_valid", i), {31'd0, imem_req_valid}, {31'd0, r.e_req});
      chk($sformatf("v%0d_req_addr", i), imem_req_addr, pc_q);
      chk($sformatf("v%0d_next_pc", i), next_pc, r.e_npc);
      chk($sformatf("v%0d_inst_valid", i), {31'd0, inst_valid}, {31'd0, r.e_iv});
      chk($sformatf("v%0d_inst_pc", i), inst_pc, r.e_ipc);
      chk($sformatf("v%0d_fault", i), {31'd0, fetch_fault}, {31'd0, r.e_flt});
      if (r.e_iv) begin
        exp_d = (sb.size() > 0) ? sb[0].data : 32'hDEADBEEF;
        exp_p = (sb.size() > 0) ? sb[0].pc : 32'hDEADBEEF;
      end else begin
        exp_d = 32'd0;
        exp_p = 32'd0;
      end
      chk($sformatf("v%0d_inst_data", i), inst_data, exp_d);
      chk($sformatf("v%0d_sb_pc", i), inst_pc, exp_p);
      // Memory responder tracks the address it accepted
      if (imem_req_valid && imem_req_ready) mem_addr = imem_req_addr;
      if (r.e_req && r.mreq) acc = pc_q;
      if (r.e_iv && r.rdy && !r.rv && (sb.size() > 0)) void'(sb.pop_front());
      if (r.rv) sb.delete();
      if (r.rsp == 2'd1) sb.push_back({acc, mem_word(acc)});
      pc_q = r.e_npc;
      @(posedge clk);
      #1;
    end

    // Async reset during WAIT with a buffered entry: clears without a clock edge
    pc = pc_q;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    inst_ready = 1'b0;
    #1;
    chk("pre_rst_inst_valid", {31'd0, inst_valid}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("async_rst_fault", {31'd0, fetch_fault}, 32'd0);
    chk("async_rst_inst_pc", inst_pc, 32'd0);
    reset = 1'b1;
    pc = 32'd0;
    #1;
    chk("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("post_rst_next_pc", next_pc, 32'd4);

    // Set a fault, then async reset clears it immediately
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    pc = 32'h6;
    #1;
    chk("flt_set", {31'd0, fetch_fault}, 32'd1);
    chk("flt_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("flt_next_pc", next_pc, 32'h6);
    reset = 1'b0;
    #1;
    chk("flt_async_clear", {31'd0, fetch_fault}, 32'd0);
    reset = 1'b1;
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
